spi_txn_sequencer: RTL and testbench
====================================

// Module: spi_txn_sequencer
// PURPOSE
//  Queues CPU byte commands for the SPI peripheral engine (spi_ctrl) and sequences them: issues
//  one start per byte, waits out busy, optionally captures the MISO byte into a response queue.
//  Sits between the peripheral register decode (SPI data/status addresses) and spi_ctrl,
//  so the CPU can post a whole display/sensor transaction without polling busy per byte.
// PARAMETERS
//  TX_DEPTH  4  command FIFO entries; power of 2, >=2
//  RX_DEPTH  4  response FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  cmd_valid    in   1   CPU write to SPI data register this cycle
//  cmd_data     in   11  {capture, dc, end_txn, byte[7:0]}
//  cmd_ready    out  1   command FIFO not full
//  rsp_read     in   1   CPU read of SPI data register (pop response)
//  rsp_valid    out  1   response FIFO not empty
//  rsp_data     out  8   head of response FIFO; 8'hFF when empty
//  tx_level     out  $clog2(TX_DEPTH)+1  command FIFO occupancy
//  rx_level     out  $clog2(RX_DEPTH)+1  response FIFO occupancy
//  idle         out  1   FSM in IDLE and command FIFO empty
//  overflow     out  1   sticky: command dropped because FIFO full
//  clr_overflow in   1   clears overflow
//  spi_start    out  1   one-cycle start pulse to spi_ctrl
//  spi_byte     out  8   byte to send, valid while spi_start=1
//  spi_dc       out  1   dc flag, valid while spi_start=1
//  spi_end_txn  out  1   deassert CS after this byte, valid while spi_start=1
//  spi_busy     in   1   spi_ctrl busy; rises the cycle after spi_start
//  spi_rx_byte  in   8   spi_ctrl received byte, valid when busy falls
// BEHAVIOUR
//  Reset: both FIFOs empty, FSM=IDLE, spi_start=0, spi_byte/dc/end_txn=0, overflow=0,
//   cmd_ready=1, rsp_valid=0, rsp_data=8'hFF, idle=1. Reset mid-byte abandons it; spi_ctrl
//   shares rst. Reset dominates clr_overflow and all pushes/pops.
//  Push: cmd_valid && cmd_ready writes cmd_data at the edge. cmd_valid && !cmd_ready drops the
//   command and sets overflow; a same-cycle ISSUE pop does not make room (cmd_ready is pre-pop).
//   clr_overflow coincident with a drop: overflow ends set.
//  FSM states (registered):
//   IDLE     : if TX non-empty and !(head.capture && RX full) -> ISSUE; else stay.
//   ISSUE    : spi_start=1, spi_byte/dc/end_txn from TX head; TX popped this cycle; latch capture
//              bit -> WAIT_START.
//   WAIT_START: one cycle, spi_start=0 -> WAIT_DONE.
//   WAIT_DONE: while spi_busy stay; when spi_busy=0: if latched capture push spi_rx_byte into RX
//              (space guaranteed by IDLE check) -> IDLE. Non-capture bytes discard rx data.
//  Latency: command accepted at edge k into empty idle block -> spi_start high in cycle k+1 is
//   FALSE; IDLE decides in cycle k+1, ISSUE (spi_start=1) in cycle k+2. Back-to-back bytes:
//   busy falling cycle in WAIT_DONE, then IDLE, then next ISSUE (2-cycle gap after busy low).
//  RX: rsp_read && rsp_valid pops; rsp_read when empty ignored. Simultaneous push+pop: level
//   unchanged, data order preserved (FIFO), push into full impossible by construction.
//  Levels: counters saturate never; width holds DEPTH exactly. Pointers wrap modulo DEPTH.
//  idle=1 only when FSM=IDLE and tx_level=0 (RX content irrelevant).
// STRUCTURE
//  Package spi_seq_pkg: FSM state enum (IDLE, ISSUE, WAIT_START, WAIT_DONE), cmd field bit
//   positions (CMD_CAPTURE=10, CMD_DC=9, CMD_END=8), cmd width constant 11.
//  Sub-module: sync_fifo #(WIDTH, DEPTH) with push/pop/full/empty/level, instantiated twice
//   (TX width 11, RX width 8). Sequencer FSM + overflow flag in this file.
// TESTING
//  Reset, then push {cap=0,dc=1,end=1,8'hA5}: spi_start exactly one cycle, 2 cycles after accept,
//   spi_byte=A5 dc=1 end_txn=1; model busy 16 cycles; idle returns 1; rx_level stays 0.
//  Push 3 capture bytes 11,22,33 with model returning 5A,6B,7C: exactly 3 starts in order,
//   rx_level=3, reads return 5A,6B,7C then rsp_data=FF, rsp_valid=0.
//  Fill TX (4) while busy held high, push 5th 8'hEE: cmd_ready=0, overflow=1, EE never sent;
//   clr_overflow -> 0; clr_overflow and drop same cycle -> stays 1.
//  RX full (4 unread captures) with capture cmd pending: no spi_start until one rsp_read, then
//   issue resumes; non-capture head with RX full issues normally.
//  Assert rst during WAIT_DONE with 3 queued: next cycle spi_start=0, levels 0, idle=1,
//   no further starts after release.
//  Simultaneous rsp_read and capture push at rx_level=2: level stays 2, order preserved.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM states and the
// field layout of an 11-bit CPU command word {capture, dc, end_txn, byte}.
package spi_seq_pkg;

   // Command word layout
   localparam int CMD_W       = 11;
   localparam int CMD_CAPTURE = 10;
   localparam int CMD_DC      = 9;
   localparam int CMD_END     = 8;
   localparam int BYTE_W      = 8;

   // Value presented on the response port when nothing is queued
   localparam logic [BYTE_W-1:0] RSP_EMPTY = 8'hFF;

   // Sequencer states: decide, pulse start, let busy rise, wait for busy to fall
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ISSUE      = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. Pushes into a full
// FIFO and pops from an empty one are ignored, so callers may gate loosely.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Advance pointers and track occupancy; a simultaneous push and pop leaves the count alone
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; the occupancy count decides what is meaningful
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Queues CPU byte commands for spi_ctrl and plays them out one at a time:
// one start pulse per byte, wait for busy to drop, and optionally capture the
// received byte into a response queue the CPU reads back later. A capture byte
// is held back while the response queue is full so its data can never be lost.
module spi_txn_sequencer
   import spi_seq_pkg::*;
#(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   input  logic [CMD_W-1:0]            cmd_data,
   output logic                        cmd_ready,
   input  logic                        rsp_read,
   output logic                        rsp_valid,
   output logic [BYTE_W-1:0]           rsp_data,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic                        idle,
   output logic                        overflow,
   input  logic                        clr_overflow,
   output logic                        spi_start,
   output logic [BYTE_W-1:0]           spi_byte,
   output logic                        spi_dc,
   output logic                        spi_end_txn,
   input  logic                        spi_busy,
   input  logic [BYTE_W-1:0]           spi_rx_byte
);

   seq_state_t        state;
   seq_state_t        state_next;
   logic [CMD_W-1:0]  tx_head;
   logic [BYTE_W-1:0] rx_head;
   logic              tx_full;
   logic              tx_empty;
   logic              rx_full;
   logic              rx_empty;
   logic              tx_push;
   logic              tx_pop;
   logic              rx_push;
   logic              rx_pop;
   logic              capture_q;
   logic              drop;

   // Room is judged before any same-cycle issue pop, so a full queue always drops
   assign cmd_ready = !tx_full;
   assign tx_push   = cmd_valid && !tx_full;
   assign drop      = cmd_valid && tx_full;

   assign rsp_valid = !rx_empty;
   assign rsp_data  = rx_empty ? RSP_EMPTY : rx_head;
   assign rx_pop    = rsp_read && !rx_empty;

   assign idle      = (state == IDLE) && tx_empty;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (tx_push),
      .pop     (tx_pop),
      .wr_data (cmd_data),
      .rd_data (tx_head),
      .full    (tx_full),
      .empty   (tx_empty),
      .level   (tx_level)
   );

   sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (rx_push),
      .pop     (rx_pop),
      .wr_data (spi_rx_byte),
      .rd_data (rx_head),
      .full    (rx_full),
      .empty   (rx_empty),
      .level   (rx_level)
   );

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Remember whether the byte in flight wants its received data kept
   always_ff @(posedge clk) begin
      if (rst) begin
         capture_q <= 1'b0;
      end else if (state == ISSUE) begin
         capture_q <= tx_head[CMD_CAPTURE];
      end
   end

   // Sticky overflow: a drop wins over a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_overflow) begin
         overflow <= 1'b0;
      end
   end

   // Next-state and per-state outputs; the byte fields are only driven during the start pulse
   always_comb begin
      state_next  = state;
      spi_start   = 1'b0;
      spi_byte    = '0;
      spi_dc      = 1'b0;
      spi_end_txn = 1'b0;
      tx_pop      = 1'b0;
      rx_push     = 1'b0;
      case (state)
         IDLE: begin
            if (!tx_empty && !(tx_head[CMD_CAPTURE] && rx_full)) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            spi_start   = 1'b1;
            spi_byte    = tx_head[BYTE_W-1:0];
            spi_dc      = tx_head[CMD_DC];
            spi_end_txn = tx_head[CMD_END];
            tx_pop      = 1'b1;
            state_next  = WAIT_START;
         end
         WAIT_START: begin
            state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!spi_busy) begin
               rx_push    = capture_q;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Self-checking bench for spi_txn_sequencer. A small spi_ctrl model answers
// start pulses with a busy window and a returned byte; the reference model is
// just queues of accepted commands and expected responses.
module tb_spi_txn_sequencer;

   localparam int TX_DEPTH = 4;
   localparam int RX_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [10:0] cmd_data;
   logic        cmd_ready;
   logic        rsp_read;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic [2:0]  tx_level;
   logic [2:0]  rx_level;
   logic        idle;
   logic        overflow;
   logic        clr_overflow;
   logic        spi_start;
   logic [7:0]  spi_byte;
   logic        spi_dc;
   logic        spi_end_txn;
   logic        spi_busy = 1'b0;
   logic [7:0]  spi_rx_byte = 8'h00;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   // Peripheral model knobs and logs
   int          busy_len = 4;
   bit          hold_busy = 1'b0;
   int          busy_cnt = 0;
   logic [7:0]  rx_src[$];
   logic [9:0]  issued_log[$];
   logic [7:0]  rx_log[$];
   int          start_cycle[$];

   // Reference model: accepted commands in order, responses the CPU should see
   logic [10:0] exp_cmds[$];
   logic [7:0]  exp_rsp[$];
   int          synced = 0;

   spi_txn_sequencer #(
      .TX_DEPTH (TX_DEPTH),
      .RX_DEPTH (RX_DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_data     (cmd_data),
      .cmd_ready    (cmd_ready),
      .rsp_read     (rsp_read),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .tx_level     (tx_level),
      .rx_level     (rx_level),
      .idle         (idle),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .spi_start    (spi_start),
      .spi_byte     (spi_byte),
      .spi_dc       (spi_dc),
      .spi_end_txn  (spi_end_txn),
      .spi_busy     (spi_busy),
      .spi_rx_byte  (spi_rx_byte)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used to time start pulses
   always @(posedge clk) cycle <= cycle + 1;

   // spi_ctrl stand-in: busy rises after a start, lasts busy_len cycles, returned byte held from start
   always @(posedge clk) begin
      if (rst) begin
         spi_busy <= 1'b0;
         busy_cnt <= 0;
      end else if (spi_start) begin
         issued_log.push_back({spi_dc, spi_end_txn, spi_byte});
         start_cycle.push_back(cycle);
         if (rx_src.size() == 0) rx_src.push_back(8'($urandom));
         rx_log.push_back(rx_src[0]);
         spi_rx_byte <= rx_src.pop_front();
         spi_busy <= 1'b1;
         busy_cnt <= busy_len;
      end else if (spi_busy && !hold_busy) begin
         if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
         else spi_busy <= 1'b0;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one command; the model predicts acceptance from its own occupancy count
   task automatic apply_stimulus(input logic [10:0] cmd);
      bit room;
      room = (exp_cmds.size() - issued_log.size()) < TX_DEPTH;
      cmd_valid = 1'b1;
      cmd_data  = cmd;
      check_output("cmd_ready", 32'(cmd_ready), 32'(room));
      tick();
      cmd_valid = 1'b0;
      if (room) exp_cmds.push_back(cmd);
   endtask

   // Compare newly issued bytes with accepted commands in order; queue expected responses
   task automatic sync_model();
      check_output("issue_count", issued_log.size(), exp_cmds.size());
      while (synced < issued_log.size() && synced < exp_cmds.size()) begin
         check_output("issue_order", 32'(issued_log[synced]), 32'(exp_cmds[synced][9:0]));
         if (exp_cmds[synced][10]) exp_rsp.push_back(rx_log[synced]);
         synced++;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!idle && n < budget) begin
         tick();
         n++;
      end
      check_output("idle_wait", 32'(idle), 32'd1);
      sync_model();
   endtask

   task automatic wait_busy(input logic lvl, input int budget);
      int n = 0;
      while (spi_busy !== lvl && n < budget) begin
         tick();
         n++;
      end
      check_output("busy_wait", 32'(spi_busy), 32'(lvl));
   endtask

   // Pop one response, checking it against the model head (or the empty value)
   task automatic read_rsp();
      logic [7:0] e;
      if (exp_rsp.size() == 0) begin
         check_output("rsp_valid_empty", 32'(rsp_valid), 32'd0);
         check_output("rsp_data_empty", 32'(rsp_data), 32'hFF);
      end else begin
         e = exp_rsp.pop_front();
         check_output("rsp_valid", 32'(rsp_valid), 32'd1);
         check_output("rsp_data", 32'(rsp_data), 32'(e));
      end
      rsp_read = 1'b1;
      tick();
      rsp_read = 1'b0;
   endtask

   initial begin
      int base;
      int n0;
      int nb;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_data = '0;
      rsp_read = 1'b0;
      clr_overflow = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      $display("[TB] reset values");
      check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("rst_rsp_data", 32'(rsp_data), 32'hFF);
      check_output("rst_idle", 32'(idle), 32'd1);
      check_output("rst_tx_level", 32'(tx_level), 32'd0);
      check_output("rst_rx_level", 32'(rx_level), 32'd0);
      check_output("rst_overflow", 32'(overflow), 32'd0);
      check_output("rst_spi_start", 32'(spi_start), 32'd0);
      check_output("rst_spi_fields", 32'({spi_dc, spi_end_txn, spi_byte}), 32'd0);

      $display("[TB] single byte latency");
      busy_len = 16;
      apply_stimulus({1'b0, 1'b1, 1'b1, 8'hA5});
      check_output("lat_start_early", 32'(spi_start), 32'd0);
      check_output("lat_tx_level", 32'(tx_level), 32'd1);
      tick();
      check_output("lat_start", 32'(spi_start), 32'd1);
      check_output("lat_fields", 32'({spi_dc, spi_end_txn, spi_byte}), 32'h3A5);
      tick();
      check_output("lat_start_one_cycle", 32'(spi_start), 32'd0);
      wait_idle(100);
      check_output("lat_rx_level", 32'(rx_level), 32'd0);

      $display("[TB] three captures");
      busy_len = 5;
      rx_src.push_back(8'h5A);
      rx_src.push_back(8'h6B);
      rx_src.push_back(8'h7C);
      base = start_cycle.size();
      apply_stimulus({1'b1, 2'b00, 8'h11});
      apply_stimulus({1'b1, 2'b00, 8'h22});
      apply_stimulus({1'b1, 2'b00, 8'h33});
      wait_idle(200);
      if (start_cycle.size() >= base + 3) begin
         check_output("gap_1", start_cycle[base+1] - start_cycle[base], busy_len + 3);
         check_output("gap_2", start_cycle[base+2] - start_cycle[base+1], busy_len + 3);
      end
      check_output("cap_rx_level", 32'(rx_level), 32'd3);
      read_rsp();
      read_rsp();
      read_rsp();
      read_rsp();
      check_output("cap_rx_drained", 32'(rx_level), 32'd0);

      $display("[TB] overflow");
      busy_len = 3;
      hold_busy = 1'b1;
      for (int i = 1; i <= 5; i++) apply_stimulus({3'b000, 8'(i)});
      check_output("ovf_tx_full", 32'(tx_level), 32'd4);
      apply_stimulus({3'b000, 8'hEE});
      check_output("ovf_set", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check_output("ovf_clr", 32'(overflow), 32'd0);
      clr_overflow = 1'b1;
      apply_stimulus({3'b000, 8'hEE});
      clr_overflow = 1'b0;
      check_output("ovf_clr_vs_drop", 32'(overflow), 32'd1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      hold_busy = 1'b0;
      wait_idle(300);

      $display("[TB] response queue full");
      busy_len = 2;
      for (int i = 0; i < 4; i++) apply_stimulus({1'b1, 2'b01, 8'(8'h40 + i)});
      wait_idle(200);
      check_output("rxf_level", 32'(rx_level), 32'd4);
      n0 = issued_log.size();
      apply_stimulus({1'b1, 2'b00, 8'h99});
      repeat (12) tick();
      check_output("rxf_stall", issued_log.size(), n0);
      check_output("rxf_not_idle", 32'(idle), 32'd0);
      check_output("rxf_tx_level", 32'(tx_level), 32'd1);
      read_rsp();
      wait_idle(100);
      check_output("rxf_resumed", issued_log.size(), n0 + 1);
      check_output("rxf_level2", 32'(rx_level), 32'd4);
      apply_stimulus({1'b0, 2'b01, 8'h77});
      wait_idle(100);
      check_output("rxf_noncap", 32'(rx_level), 32'd4);
      for (int i = 0; i < 4; i++) read_rsp();
      check_output("rxf_drained", 32'(rx_level), 32'd0);

      $display("[TB] simultaneous push and pop");
      apply_stimulus({1'b1, 2'b00, 8'hC1});
      apply_stimulus({1'b1, 2'b00, 8'hC2});
      wait_idle(100);
      check_output("sim_level_pre", 32'(rx_level), 32'd2);
      busy_len = 4;
      apply_stimulus({1'b1, 2'b00, 8'h3C});
      wait_busy(1'b1, 20);
      wait_busy(1'b0, 20);
      read_rsp();
      check_output("sim_level", 32'(rx_level), 32'd2);
      wait_idle(20);
      read_rsp();
      read_rsp();
      check_output("sim_drained", 32'(rx_level), 32'd0);

      $display("[TB] reset mid byte");
      hold_busy = 1'b1;
      for (int i = 0; i < 4; i++) apply_stimulus({3'b000, 8'(8'hA0 + i)});
      wait_busy(1'b1, 20);
      tick();
      tick();
      check_output("rmid_queued", 32'(tx_level), 32'd3);
      rst = 1'b1;
      tick();
      check_output("rmid_start", 32'(spi_start), 32'd0);
      check_output("rmid_tx_level", 32'(tx_level), 32'd0);
      check_output("rmid_rx_level", 32'(rx_level), 32'd0);
      check_output("rmid_idle", 32'(idle), 32'd1);
      rst = 1'b0;
      hold_busy = 1'b0;
      exp_cmds.delete();
      exp_rsp.delete();
      issued_log.delete();
      rx_log.delete();
      start_cycle.delete();
      rx_src.delete();
      synced = 0;
      repeat (30) tick();
      check_output("rmid_no_start", issued_log.size(), 0);
      check_output("rmid_idle_after", 32'(idle), 32'd1);

      $display("[TB] random batches");
      for (int b = 0; b < 12; b++) begin
         nb = $urandom_range(1, 4);
         busy_len = $urandom_range(1, 6);
         for (int i = 0; i < nb; i++) begin
            apply_stimulus({1'($urandom_range(0, 1)), 10'($urandom)});
            repeat ($urandom_range(0, 3)) tick();
         end
         wait_idle(400);
         check_output("rnd_rx_level", 32'(rx_level), exp_rsp.size());
         while (exp_rsp.size() > 0) read_rsp();
         check_output("rnd_rsp_valid", 32'(rsp_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
